// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS32 pipeline: load/store over a req/ack data-memory
// port, branch resolution back to fetch, and the MEM/WB latch.
module memory_stage #(
    parameter int unsigned DMEM_AW = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_f,
    input  logic [2:0]         type34,
    input  logic [31:0]        INS34,
    input  logic [31:0]        ALUout34,
    input  logic [31:0]        B34,
    input  logic               cond34,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic               mem_stall,
    output logic               take_branch,
    output logic [31:0]        branch_pc,
    output logic [2:0]         type45,
    output logic [31:0]        INS45,
    output logic [31:0]        ALUout45,
    output logic [31:0]        LMD45,
    output logic               mem_err
);

    localparam logic [2:0] T_RR     = 3'b000;
    localparam logic [2:0] T_RI     = 3'b001;
    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_HALT   = 3'b101;
    localparam logic [2:0] T_BUBBLE = 3'b111;

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t             state, state_nx;
    logic               dmem_req_nx, dmem_we_nx;
    logic [DMEM_AW-1:0] dmem_addr_nx;
    logic [31:0]        dmem_wdata_nx;
    logic               take_branch_nx;
    logic [31:0]        branch_pc_nx;
    logic [2:0]         type45_nx;
    logic [31:0]        INS45_nx, ALUout45_nx, LMD45_nx;
    logic               mem_err_nx;
    logic [2:0]         hold_type, hold_type_nx;
    logic [31:0]        hold_ins, hold_ins_nx;
    logic [31:0]        hold_alu, hold_alu_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    // Ack is only meaningful while a request is outstanding, i.e. in ACCESS.
    assign mem_stall = (state == ACCESS) && !dmem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            take_branch <= 1'b0;
            branch_pc   <= '0;
            type45      <= T_BUBBLE;
            INS45       <= '0;
            ALUout45    <= '0;
            LMD45       <= '0;
            mem_err     <= 1'b0;
            hold_type   <= T_BUBBLE;
            hold_ins    <= '0;
            hold_alu    <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            dmem_req    <= dmem_req_nx;
            dmem_we     <= dmem_we_nx;
            dmem_addr   <= dmem_addr_nx;
            dmem_wdata  <= dmem_wdata_nx;
            take_branch <= take_branch_nx;
            branch_pc   <= branch_pc_nx;
            type45      <= type45_nx;
            INS45       <= INS45_nx;
            ALUout45    <= ALUout45_nx;
            LMD45       <= LMD45_nx;
            mem_err     <= mem_err_nx;
            hold_type   <= hold_type_nx;
            hold_ins    <= hold_ins_nx;
            hold_alu    <= hold_alu_nx;
            cnt         <= cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        dmem_req_nx    = dmem_req;
        dmem_we_nx     = dmem_we;
        dmem_addr_nx   = dmem_addr;
        dmem_wdata_nx  = dmem_wdata;
        take_branch_nx = 1'b0;
        branch_pc_nx   = branch_pc;
        type45_nx      = type45;
        INS45_nx       = INS45;
        ALUout45_nx    = ALUout45;
        LMD45_nx       = LMD45;
        mem_err_nx     = mem_err;
        hold_type_nx   = hold_type;
        hold_ins_nx    = hold_ins;
        hold_alu_nx    = hold_alu;
        cnt_nx         = cnt;

        case (state)
            IDLE: begin
                if (!halt_f) begin
                    case (type34)
                        T_RR, T_RI, T_HALT: begin
                            type45_nx   = type34;
                            INS45_nx    = INS34;
                            ALUout45_nx = ALUout34;
                        end
                        T_BRANCH: begin
                            take_branch_nx = cond34;
                            branch_pc_nx   = ALUout34;
                            type45_nx      = T_BUBBLE;
                            INS45_nx       = INS34;
                        end
                        T_LOAD, T_STORE: begin
                            state_nx      = ACCESS;
                            dmem_req_nx   = 1'b1;
                            dmem_we_nx    = (type34 == T_STORE);
                            dmem_addr_nx  = ALUout34[DMEM_AW-1:0];
                            dmem_wdata_nx = B34;
                            hold_type_nx  = type34;
                            hold_ins_nx   = INS34;
                            hold_alu_nx   = ALUout34;
                            type45_nx     = T_BUBBLE;
                            cnt_nx        = '0;
                        end
                        default: type45_nx = T_BUBBLE;
                    endcase
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_nx    = IDLE;
                    dmem_req_nx = 1'b0;
                    type45_nx   = hold_type;
                    INS45_nx    = hold_ins;
                    ALUout45_nx = hold_alu;
                    if (hold_type == T_LOAD) LMD45_nx = dmem_rdata;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    // Abandon the access; the instruction never reaches writeback.
                    state_nx    = IDLE;
                    dmem_req_nx = 1'b0;
                    mem_err_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: scoreboarded MEM/WB results against a
// latency-programmable data-memory responder.
module tb_memory_stage;

    localparam logic [2:0] T_RR     = 3'b000;
    localparam logic [2:0] T_RI     = 3'b001;
    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_HALT   = 3'b101;
    localparam logic [2:0] T_BUBBLE = 3'b111;

    logic        clk, rst, halt_f;
    logic [2:0]  type34;
    logic [31:0] INS34, ALUout34, B34;
    logic        cond34;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack, mem_stall, take_branch;
    logic [31:0] branch_pc;
    logic [2:0]  type45;
    logic [31:0] INS45, ALUout45, LMD45;
    logic        mem_err;

    memory_stage #(.DMEM_AW(10), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .halt_f(halt_f),
        .type34(type34), .INS34(INS34), .ALUout34(ALUout34), .B34(B34), .cond34(cond34),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .take_branch(take_branch), .branch_pc(branch_pc),
        .type45(type45), .INS45(INS45), .ALUout45(ALUout45), .LMD45(LMD45),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after ack_lat wait cycles of an outstanding request.
    logic        ack_en, ack_force;
    int          ack_lat;
    logic [7:0]  wait_cnt;
    logic [31:0] rdata_val;
    assign dmem_rdata = rdata_val;
    assign dmem_ack   = (dmem_req && ack_en && (wait_cnt == 8'(ack_lat))) || ack_force;
    always @(posedge clk) begin
        if (!dmem_req || dmem_ack) wait_cnt <= 8'd0;
        else                       wait_cnt <= wait_cnt + 8'd1;
    end

    typedef struct {
        logic [2:0]  t;
        logic [31:0] ins;
        logic [31:0] alu;
        logic [31:0] lmd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_exp;
    logic [31:0] lmd_model;
    int          n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic push_exp(input logic [2:0] t, input logic [31:0] ins, input logic [31:0] alu);
        exp_t e;
        e.t = t; e.ins = ins; e.alu = alu;
        if (t == T_LOAD) lmd_model = rdata_val;
        e.lmd = lmd_model;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_type45"},   32'(type45), 32'(e.t));
        check({tag, "_INS45"},    INS45,       e.ins);
        check({tag, "_ALUout45"}, ALUout45,    e.alu);
        check({tag, "_LMD45"},    LMD45,       e.lmd);
        last_exp = e;
    endtask

    // Presents one EX/MEM entry for a single edge, then freezes the pipeline.
    task automatic drive(input logic [2:0] t, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] b, input logic c);
        halt_f = 1'b0; type34 = t; INS34 = ins; ALUout34 = alu; B34 = b; cond34 = c;
        @(posedge clk); #1;
        halt_f = 1'b1; type34 = T_BUBBLE;
    endtask

    task automatic alu_op(input string tag, input logic [2:0] t, input logic [31:0] ins,
                          input logic [31:0] alu);
        push_exp(t, ins, alu);
        halt_f = 1'b0; type34 = t;
        #0;
        check({tag, "_no_stall"}, 32'(mem_stall), 32'd0);
        drive(t, ins, alu, 32'h0, 1'b0);
        pop_check(tag);
    endtask

    task automatic mem_op(input string tag, input logic [2:0] t, input logic [31:0] ins,
                          input logic [31:0] alu, input logic [31:0] b, input int lat);
        int stalls;
        ack_en = 1'b1; ack_lat = lat;
        push_exp(t, ins, alu);
        drive(t, ins, alu, b, 1'b0);
        check({tag, "_req"},    32'(dmem_req),  32'd1);
        check({tag, "_we"},     32'(dmem_we),   32'(t == T_STORE));
        check({tag, "_addr"},   32'(dmem_addr), 32'(alu[9:0]));
        check({tag, "_bubble"}, 32'(type45),    32'(T_BUBBLE));
        if (t == T_STORE) check({tag, "_wdata"}, dmem_wdata, b);
        stalls = 0;
        while (mem_stall && stalls < 20) begin
            @(posedge clk); #1;
            stalls++;
        end
        check({tag, "_stalls"}, 32'(stalls), 32'(lat));
        @(posedge clk); #1;
        check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        pop_check(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0; n_pass = 0; lmd_model = 32'h0;
        rst = 1'b1; halt_f = 1'b1; type34 = T_BUBBLE; INS34 = '0; ALUout34 = '0; B34 = '0;
        cond34 = 1'b0; ack_en = 1'b1; ack_force = 1'b0; ack_lat = 0; rdata_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_type45", 32'(type45), 32'(T_BUBBLE));
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_tb", 32'(take_branch), 32'd0);
        check("rst_LMD45", LMD45, 32'h0);
        rst = 1'b0;

        alu_op("rr", T_RR, 32'h0022_1820, 32'h0000_1234);

        // Frozen pipeline: MEM/WB must hold.
        type34 = T_RI; INS34 = 32'h2001_0005; ALUout34 = 32'h5555; halt_f = 1'b1;
        @(posedge clk); #1;
        check("halt_type45", 32'(type45), 32'(last_exp.t));
        check("halt_ALUout45", ALUout45, last_exp.alu);
        type34 = T_BUBBLE;

        rdata_val = 32'hDEAD_BEEF;
        mem_op("load3", T_LOAD, 32'h8C22_0040, 32'h0000_0040, 32'h0, 2);
        mem_op("store0", T_STORE, 32'hAC23_0008, 32'h0000_0008, 32'hCAFE_0001, 0);
        alu_op("ri", T_RI, 32'h2003_0007, 32'h0000_0007);

        drive(T_BRANCH, 32'h1040_0010, 32'h0000_0100, 32'h0, 1'b1);
        check("br1_pulse", 32'(take_branch), 32'd1);
        check("br1_pc", branch_pc, 32'h0000_0100);
        check("br1_type45", 32'(type45), 32'(T_BUBBLE));
        check("br1_INS45", INS45, 32'h1040_0010);
        @(posedge clk); #1;
        check("br1_one_cycle", 32'(take_branch), 32'd0);

        drive(T_BRANCH, 32'h1040_0020, 32'h0000_0200, 32'h0, 1'b0);
        check("br0_no_pulse", 32'(take_branch), 32'd0);
        check("br0_type45", 32'(type45), 32'(T_BUBBLE));

        rdata_val = 32'h1357_9BDF;
        mem_op("load1", T_LOAD, 32'h8C24_0123, 32'h0000_0123, 32'h0, 1);

        // Timeout: no ack ever arrives.
        ack_en = 1'b0;
        drive(T_LOAD, 32'h8C25_0044, 32'h0000_0044, 32'h0, 1'b0);
        n = 0;
        while (dmem_req && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("to_req_cycles", 32'(n), 32'd4);
        check("to_err", 32'(mem_err), 32'd1);
        check("to_type45", 32'(type45), 32'(T_BUBBLE));
        ack_en = 1'b1;
        alu_op("post_to", T_HALT, 32'hFC00_0000, 32'h0000_0ABC);
        check("to_err_sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of an outstanding access.
        ack_en = 1'b0;
        drive(T_LOAD, 32'h8C26_0050, 32'h0000_0050, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_type45", 32'(type45), 32'(T_BUBBLE));
        check("rstmid_err", 32'(mem_err), 32'd0);
        check("rstmid_stall", 32'(mem_stall), 32'd0);
        ack_force = 1'b1; rdata_val = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        ack_force = 1'b0;
        check("late_ack_type45", 32'(type45), 32'(T_BUBBLE));
        check("late_ack_LMD45", LMD45, 32'h0);
        check("late_ack_req", 32'(dmem_req), 32'd0);
        lmd_model = 32'h0;

        ack_en = 1'b1;
        rdata_val = 32'h0F0F_00FF;
        mem_op("load_after_rst", T_LOAD, 32'h8C27_0003, 32'h0000_0003, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
